// File: rtl/pixel_queue_writer.sv
// Pixel queue write side: raster position tagging with almost-full backpressure.
// Build option: define PIXEL_QUEUE_WRITER_PAD_EN to black-pad lines cut short by frame_start.
module pixel_queue_writer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [13:0] horizontal_size,
  input  logic [13:0] vertical_size,
  input  logic        frame_start,
  input  logic [7:0]  y_in,
  input  logic [7:0]  u_in,
  input  logic [7:0]  v_in,
  input  logic [7:0]  osd_in,
  input  logic        pixel_valid_in,
  output logic        pixel_in_ready,
  input  logic        pixel_wr_almost_full,
  output logic        pixel_wr_en,
  output logic [7:0]  y_out,
  output logic [7:0]  u_out,
  output logic [7:0]  v_out,
  output logic [7:0]  osd_out,
  output logic [2:0]  position_out,
  output logic        frame_truncated,
  output logic        size_error
);

  localparam logic [2:0] ROW_X_COL_X    = 3'd0;
  localparam logic [2:0] ROW_0_COL_0    = 3'd1;
  localparam logic [2:0] ROW_1_COL_0    = 3'd2;
  localparam logic [2:0] ROW_X_COL_0    = 3'd3;
  localparam logic [2:0] ROW_X_COL_LAST = 3'd4;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
`ifdef PIXEL_QUEUE_WRITER_PAD_EN
  localparam logic [1:0] STATE_PAD  = 2'd2;
`endif
  localparam logic [1:0] STATE_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [13:0] r_h_cnt;
  logic [13:0] r_v_cnt;
  logic [13:0] r_h_size;
  logic [13:0] r_v_size;
  logic        r_wr_en;
  logic [7:0]  r_y;
  logic [7:0]  r_u;
  logic [7:0]  r_v;
  logic [7:0]  r_osd;
  logic [2:0]  r_pos;
  logic        r_trunc;
  logic        r_size_err;

  function automatic logic [2:0] f_tag(
    input logic [13:0] h,
    input logic [13:0] v,
    input logic [13:0] hs
  );
    if (h == 14'd0 && v == 14'd0)   return ROW_0_COL_0;
    else if (h == 14'd0 && v == 14'd1) return ROW_1_COL_0;
    else if (h == 14'd0)            return ROW_X_COL_0;
    else if (h == hs - 14'd1)       return ROW_X_COL_LAST;
    else                            return ROW_X_COL_X;
  endfunction

  logic        w_run;
  logic        w_mid;
  logic        w_bad;
  logic        w_pad_pend;
  logic        w_fs_new;
  logic        w_accept;
  logic [13:0] w_h_cur;
  logic [13:0] w_v_cur;
  logic [13:0] w_hs_cur;
  logic [13:0] w_vs_cur;
  logic        w_last_col;

  assign w_run = r_state == STATE_RUN;
  assign w_mid = (r_h_cnt != 14'd0) || (r_v_cnt != 14'd0);
  assign w_bad = (horizontal_size < 14'd2) || (vertical_size == 14'd0);

`ifdef PIXEL_QUEUE_WRITER_PAD_EN
  logic [13:0] r_ph_size;
  logic [13:0] r_pv_size;
  logic        w_pad_go;
  logic        w_in_pad;
  logic [13:0] w_ph_nxt;
  logic [13:0] w_pv_nxt;
  logic        w_pbad;

  assign w_pad_go   = frame_start && w_run && (r_h_cnt != 14'd0);
  assign w_in_pad   = r_state == STATE_PAD;
  assign w_pad_pend = w_in_pad || w_pad_go;
  assign w_ph_nxt   = frame_start ? horizontal_size : r_ph_size;
  assign w_pv_nxt   = frame_start ? vertical_size : r_pv_size;
  assign w_pbad     = (w_ph_nxt < 14'd2) || (w_pv_nxt == 14'd0);
`else
  assign w_pad_pend = 1'b0;
`endif

  // A frame_start that restarts immediately makes the pixel in the same cycle pixel 0.
  assign w_fs_new   = frame_start && !w_pad_pend;
  assign w_h_cur    = w_fs_new ? 14'd0 : r_h_cnt;
  assign w_v_cur    = w_fs_new ? 14'd0 : r_v_cnt;
  assign w_hs_cur   = w_fs_new ? horizontal_size : r_h_size;
  assign w_vs_cur   = w_fs_new ? vertical_size : r_v_size;
  assign w_last_col = w_h_cur == w_hs_cur - 14'd1;

  assign pixel_in_ready = w_run && !pixel_wr_almost_full && !w_pad_pend;
  assign w_accept       = clk_en && pixel_valid_in && pixel_in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= STATE_IDLE;
      r_h_cnt    <= 14'd0;
      r_v_cnt    <= 14'd0;
      r_h_size   <= 14'd0;
      r_v_size   <= 14'd0;
      r_wr_en    <= 1'b0;
      r_y        <= 8'd0;
      r_u        <= 8'd0;
      r_v        <= 8'd0;
      r_osd      <= 8'd0;
      r_pos      <= ROW_X_COL_X;
      r_trunc    <= 1'b0;
      r_size_err <= 1'b0;
`ifdef PIXEL_QUEUE_WRITER_PAD_EN
      r_ph_size  <= 14'd0;
      r_pv_size  <= 14'd0;
`endif
    end else if (clk_en) begin
      r_wr_en <= 1'b0;
      r_trunc <= frame_start && w_run && w_mid;
      if (w_fs_new) begin
        r_h_size   <= horizontal_size;
        r_v_size   <= vertical_size;
        r_h_cnt    <= 14'd0;
        r_v_cnt    <= 14'd0;
        r_size_err <= w_bad;
        r_state    <= w_bad ? STATE_IDLE : STATE_RUN;
      end
`ifdef PIXEL_QUEUE_WRITER_PAD_EN
      else if (frame_start) begin
        r_ph_size <= horizontal_size;
        r_pv_size <= vertical_size;
        if (w_pad_go) r_state <= STATE_PAD;
      end
`endif
      if (w_accept) begin
        r_wr_en <= 1'b1;
        r_y     <= y_in;
        r_u     <= u_in;
        r_v     <= v_in;
        r_osd   <= osd_in;
        r_pos   <= f_tag(w_h_cur, w_v_cur, w_hs_cur);
        if (!(w_fs_new && w_bad)) begin
          if (w_last_col) begin
            r_h_cnt <= 14'd0;
            r_v_cnt <= w_v_cur + 14'd1;
            if (w_v_cur == w_vs_cur - 14'd1) r_state <= STATE_DONE;
          end else begin
            r_h_cnt <= w_h_cur + 14'd1;
          end
        end
      end
`ifdef PIXEL_QUEUE_WRITER_PAD_EN
      if (w_in_pad && !pixel_wr_almost_full) begin
        r_wr_en <= 1'b1;
        r_y     <= 8'd16;
        r_u     <= 8'd128;
        r_v     <= 8'd128;
        r_osd   <= 8'd0;
        r_pos   <= f_tag(r_h_cnt, r_v_cnt, r_h_size);
        if (r_h_cnt == r_h_size - 14'd1) begin
          r_h_size   <= w_ph_nxt;
          r_v_size   <= w_pv_nxt;
          r_h_cnt    <= 14'd0;
          r_v_cnt    <= 14'd0;
          r_size_err <= w_pbad;
          r_state    <= w_pbad ? STATE_IDLE : STATE_RUN;
        end else begin
          r_h_cnt <= r_h_cnt + 14'd1;
        end
      end
`endif
    end
  end

  assign pixel_wr_en     = r_wr_en;
  assign y_out           = r_y;
  assign u_out           = r_u;
  assign v_out           = r_v;
  assign osd_out         = r_osd;
  assign position_out    = r_pos;
  assign frame_truncated = r_trunc;
  assign size_error      = r_size_err;

endmodule
